// File: rtl/wisc_pkg.sv
// Shared constants and encodings for the 16-bit WISC core pipeline.
// Set-condition selector encoding is consumed by the MEM-stage set unit.
package wisc_pkg;

   localparam int DW    = 16;
   localparam int RW    = 3;
   localparam int SEQ_W = 16;

   typedef enum logic [1:0] {
      SET_EQ = 2'b00,
      SET_LT = 2'b01,
      SET_LE = 2'b10,
      SET_CO = 2'b11
   } set_op_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_e;

endpackage

// File: rtl/ex_mem_latch_if.sv
// EX-to-MEM bundle: EX-side instruction fields in, registered MEM-side copies out.
// The EX stage is the master; the pipeline latch is the slave.
interface ex_mem_latch_if #(
   parameter int DW = wisc_pkg::DW,
   parameter int RW = wisc_pkg::RW
);

   logic                      ex_valid;
   logic                      stall;
   logic                      flush;
   logic [DW-1:0]             ex_alu_out;
   logic                      ex_zero;
   logic                      ex_cout;
   logic                      ex_alu_msb;
   logic [1:0]                ex_set_op;
   logic                      ex_is_set;
   logic [DW-1:0]             ex_wdata;
   logic [RW-1:0]             ex_wb_reg;
   logic                      ex_reg_write;
   logic                      ex_mem_read;
   logic                      ex_mem_write;
   logic                      ex_halt;

   logic                      ex_ready;
   logic                      mem_valid;
   logic [DW-1:0]             mem_alu_out;
   logic [DW-1:0]             mem_wdata;
   logic                      mem_zero;
   logic                      mem_cout;
   logic                      mem_alu_msb;
   logic                      mem_is_set;
   logic [1:0]                mem_set_op;
   logic [RW-1:0]             mem_wb_reg;
   logic                      mem_reg_write;
   logic                      mem_mem_read;
   logic                      mem_mem_write;
   logic                      mem_halt;
   logic [wisc_pkg::SEQ_W-1:0] mem_seq;
   logic                      halted;

   modport master (
      output ex_valid, stall, flush, ex_alu_out, ex_zero, ex_cout, ex_alu_msb,
             ex_set_op, ex_is_set, ex_wdata, ex_wb_reg, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_halt,
      input  ex_ready, mem_valid, mem_alu_out, mem_wdata, mem_zero, mem_cout,
             mem_alu_msb, mem_is_set, mem_set_op, mem_wb_reg, mem_reg_write,
             mem_mem_read, mem_mem_write, mem_halt, mem_seq, halted
   );

   modport slave (
      input  ex_valid, stall, flush, ex_alu_out, ex_zero, ex_cout, ex_alu_msb,
             ex_set_op, ex_is_set, ex_wdata, ex_wb_reg, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_halt,
      output ex_ready, mem_valid, mem_alu_out, mem_wdata, mem_zero, mem_cout,
             mem_alu_msb, mem_is_set, mem_set_op, mem_wb_reg, mem_reg_write,
             mem_mem_read, mem_mem_write, mem_halt, mem_seq, halted
   );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear, load enable.
// Clear takes priority over enable so a kill always wins over a capture.
module pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q <= '0;
      end else if (i_clr) begin
         o_q <= '0;
      end else if (i_en) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall, flush, bubble insertion, sticky halt
// and a retirement sequence tag carried alongside each captured instruction.
module ex_mem_latch #(
   parameter int DW = wisc_pkg::DW,
   parameter int RW = wisc_pkg::RW
) (
   input logic           clk,
   input logic           rst_n,
   ex_mem_latch_if.slave bus
);

   import wisc_pkg::*;

   localparam int CTL_W  = 5;
   localparam int DATA_W = 2*DW + 6 + RW + SEQ_W;

   state_e              r_state;
   state_e              w_nextState;
   logic [SEQ_W-1:0]    r_seqCnt;
   logic                w_run;
   logic                w_capture;
   logic                w_kill;
   logic [DATA_W-1:0]   w_dataD;
   logic [DATA_W-1:0]   w_dataQ;
   logic [CTL_W-1:0]    w_ctlD;
   logic [CTL_W-1:0]    w_ctlQ;

   // Flush beats stall beats advance; nothing moves once halted.
   assign w_run     = (r_state == ST_RUN);
   assign w_capture = w_run & ~bus.flush & ~bus.stall & bus.ex_valid;
   assign w_kill    = w_run & (bus.flush | (~bus.stall & ~bus.ex_valid));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_RUN:    if (w_capture && bus.ex_halt) w_nextState = ST_HALTED;
         ST_HALTED: w_nextState = ST_HALTED;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seqCnt <= '0;
      end else if (w_capture) begin
         r_seqCnt <= r_seqCnt + 1'b1;
      end
   end

   // The tag travels with the data fields so it holds across flushes and bubbles.
   assign w_dataD = {bus.ex_alu_out, bus.ex_wdata, bus.ex_zero, bus.ex_cout,
                     bus.ex_alu_msb, bus.ex_is_set, bus.ex_set_op, bus.ex_wb_reg,
                     r_seqCnt};
   assign w_ctlD  = {1'b1, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                     bus.ex_halt};

   pipe_reg #(.W(DATA_W)) u_dataReg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_capture),
      .i_clr (1'b0),
      .i_d   (w_dataD),
      .o_q   (w_dataQ)
   );

   pipe_reg #(.W(CTL_W)) u_ctlReg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_capture),
      .i_clr (w_kill),
      .i_d   (w_ctlD),
      .o_q   (w_ctlQ)
   );

   assign {bus.mem_alu_out, bus.mem_wdata, bus.mem_zero, bus.mem_cout,
           bus.mem_alu_msb, bus.mem_is_set, bus.mem_set_op, bus.mem_wb_reg,
           bus.mem_seq} = w_dataQ;
   assign {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write,
           bus.mem_halt} = w_ctlQ;

   assign bus.ex_ready = rst_n & w_run & ~bus.stall;
   assign bus.halted   = (r_state == ST_HALTED);

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed bench for the EX/MEM latch: capture, stall, flush, bubble,
// sequence-tag wrap, sticky halt and asynchronous reset recovery.
module tb_ex_mem_latch;

   logic clk = 1'b0;
   logic rst_n;
   int   assertCount = 0;
   int   failCount   = 0;

   ex_mem_latch_if #(.DW(16), .RW(3)) bus ();

   ex_mem_latch #(.DW(16), .RW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // flags = {zero, cout, msb, is_set}; ctl = {reg_write, mem_read, mem_write, halt}
   task automatic applyStimulus(input logic valid, input logic [15:0] alu,
                                input logic [15:0] wdata, input logic [3:0] flags,
                                input logic [1:0] setOp, input logic [2:0] wbReg,
                                input logic [3:0] ctl);
      bus.ex_valid     = valid;
      bus.ex_alu_out   = alu;
      bus.ex_wdata     = wdata;
      {bus.ex_zero, bus.ex_cout, bus.ex_alu_msb, bus.ex_is_set} = flags;
      bus.ex_set_op    = setOp;
      bus.ex_wb_reg    = wbReg;
      {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_halt} = ctl;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin : mainSeq
      int          bad;
      logic [15:0] expSeq;
      bad    = 0;
      expSeq = 16'd4;

      rst_n     = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      applyStimulus(1'b0, 16'h0, 16'h0, 4'b0000, 2'b00, 3'd0, 4'b0000);
      #12;
      checkOutput("rst_mem_valid", bus.mem_valid, 0);
      checkOutput("rst_ex_ready", bus.ex_ready, 0);
      checkOutput("rst_halted", bus.halted, 0);
      checkOutput("rst_mem_seq", bus.mem_seq, 0);
      checkOutput("rst_alu_out", bus.mem_alu_out, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("run_ex_ready", bus.ex_ready, 1);

      $display("[TB] first capture");
      applyStimulus(1'b1, 16'h8001, 16'h0000, 4'b0010, 2'b01, 3'd3, 4'b1000);
      stepCycle();
      checkOutput("cap1_valid", bus.mem_valid, 1);
      checkOutput("cap1_alu", bus.mem_alu_out, 16'h8001);
      checkOutput("cap1_msb", bus.mem_alu_msb, 1);
      checkOutput("cap1_set_op", bus.mem_set_op, 2'b01);
      checkOutput("cap1_seq", bus.mem_seq, 0);
      checkOutput("cap1_reg_write", bus.mem_reg_write, 1);
      checkOutput("cap1_wb_reg", bus.mem_wb_reg, 3);

      applyStimulus(1'b1, 16'h1234, 16'hBEEF, 4'b1101, 2'b11, 3'd5, 4'b0010);
      stepCycle();
      checkOutput("cap2_alu", bus.mem_alu_out, 16'h1234);
      checkOutput("cap2_wdata", bus.mem_wdata, 16'hBEEF);
      checkOutput("cap2_flags", {bus.mem_zero, bus.mem_cout, bus.mem_alu_msb, bus.mem_is_set}, 4'b1101);
      checkOutput("cap2_set_op", bus.mem_set_op, 2'b11);
      checkOutput("cap2_ctl", {bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write, bus.mem_halt}, 4'b0010);
      checkOutput("cap2_seq", bus.mem_seq, 1);

      $display("[TB] stall three cycles");
      bus.stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b1, 16'h1111 * i[15:0], 16'h2222, 4'b0011, 2'b10, 3'd7, 4'b1100);
         stepCycle();
         checkOutput("stall_ex_ready", bus.ex_ready, 0);
         checkOutput("stall_alu", bus.mem_alu_out, 16'h1234);
         checkOutput("stall_seq", bus.mem_seq, 1);
         checkOutput("stall_ctl", {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_write}, 3'b101);
      end
      bus.stall = 1'b0;
      applyStimulus(1'b1, 16'hA5A5, 16'h0F00, 4'b0000, 2'b10, 3'd2, 4'b1000);
      stepCycle();
      checkOutput("release_alu", bus.mem_alu_out, 16'hA5A5);
      checkOutput("release_seq", bus.mem_seq, 2);
      checkOutput("release_set_op", bus.mem_set_op, 2'b10);

      $display("[TB] flush with stall");
      bus.flush = 1'b1;
      bus.stall = 1'b1;
      applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 4'b1111, 2'b11, 3'd1, 4'b1111);
      stepCycle();
      checkOutput("flush_valid", bus.mem_valid, 0);
      checkOutput("flush_reg_write", bus.mem_reg_write, 0);
      checkOutput("flush_alu", bus.mem_alu_out, 16'hA5A5);
      checkOutput("flush_seq", bus.mem_seq, 2);
      bus.flush = 1'b0;
      bus.stall = 1'b0;

      $display("[TB] bubble");
      applyStimulus(1'b0, 16'h7777, 16'h7777, 4'b0000, 2'b00, 3'd4, 4'b0010);
      stepCycle();
      checkOutput("bubble_mem_write", bus.mem_mem_write, 0);
      checkOutput("bubble_valid", bus.mem_valid, 0);
      checkOutput("bubble_alu", bus.mem_alu_out, 16'hA5A5);
      applyStimulus(1'b1, 16'h0101, 16'h0000, 4'b0000, 2'b00, 3'd4, 4'b0100);
      stepCycle();
      checkOutput("post_bubble_seq", bus.mem_seq, 3);
      checkOutput("post_bubble_mem_read", bus.mem_mem_read, 1);

      $display("[TB] flush with halt");
      bus.flush = 1'b1;
      applyStimulus(1'b1, 16'h4444, 16'h0000, 4'b0000, 2'b00, 3'd0, 4'b0001);
      stepCycle();
      checkOutput("flush_halt_halted", bus.halted, 0);
      checkOutput("flush_halt_mem_halt", bus.mem_halt, 0);
      checkOutput("flush_halt_ex_ready", bus.ex_ready, 1);
      bus.flush = 1'b0;

      $display("[TB] sequence wrap");
      for (int i = 0; i < 65536; i++) begin
         applyStimulus(1'b1, i[15:0], 16'h0000, 4'b0000, 2'b00, 3'd6, 4'b1000);
         stepCycle();
         if (bus.mem_seq !== expSeq) bad++;
         if (expSeq == 16'hFFFF) checkOutput("seq_ffff", bus.mem_seq, 16'hFFFF);
         if (expSeq == 16'h0000) checkOutput("seq_wrap0", bus.mem_seq, 16'h0000);
         expSeq = expSeq + 16'd1;
      end
      checkOutput("seq_stream_bad", bad, 0);

      $display("[TB] halt");
      applyStimulus(1'b1, 16'h4242, 16'h0000, 4'b0000, 2'b00, 3'd0, 4'b0001);
      stepCycle();
      checkOutput("halt_halted", bus.halted, 1);
      checkOutput("halt_mem_halt", bus.mem_halt, 1);
      checkOutput("halt_ex_ready", bus.ex_ready, 0);
      checkOutput("halt_seq", bus.mem_seq, 4);
      for (int i = 0; i < 3; i++) begin
         bus.flush = i[0];
         bus.stall = ~i[0];
         applyStimulus(1'b1, 16'h9999, 16'h9999, 4'b1111, 2'b11, 3'd7, 4'b1110);
         stepCycle();
         checkOutput("halted_hold_alu", bus.mem_alu_out, 16'h4242);
         checkOutput("halted_hold_valid", bus.mem_valid, 1);
         checkOutput("halted_hold_halted", bus.halted, 1);
      end

      $display("[TB] reset pulse");
      rst_n = 1'b0;
      #2;
      checkOutput("rst2_valid", bus.mem_valid, 0);
      checkOutput("rst2_alu", bus.mem_alu_out, 0);
      checkOutput("rst2_mem_halt", bus.mem_halt, 0);
      checkOutput("rst2_halted", bus.halted, 0);
      checkOutput("rst2_ex_ready", bus.ex_ready, 0);
      checkOutput("rst2_seq", bus.mem_seq, 0);
      rst_n     = 1'b1;
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      applyStimulus(1'b1, 16'h0F0F, 16'h0000, 4'b0000, 2'b00, 3'd1, 4'b1000);
      stepCycle();
      checkOutput("rst2_cap_seq", bus.mem_seq, 0);
      checkOutput("rst2_cap_alu", bus.mem_alu_out, 16'h0F0F);
      checkOutput("rst2_cap_halted", bus.halted, 0);
      checkOutput("rst2_cap_ex_ready", bus.ex_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
